iqdemap_multi: RTL

IQDEMAP_MULTI -- requirements
Module: iqdemap_multi

---
 rtl/iqdemap_pkg.sv | 31 +++
 rtl/iqdemap_slicer.sv | 52 +++++
 rtl/iqdemap_multi.sv | 113 +++++++++++
 3 files changed

// File: rtl/iqdemap_pkg.sv
// Shared mode constants, slicer payload type and helpers for the IQ demapper.
package iqdemap_pkg;

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_16QAM = 2'd2;

  localparam int unsigned DEFAULT_THRESH = 683;
  localparam int unsigned SYM_BITS_MAX   = 4;

  typedef struct packed {
    logic                    vld;
    logic                    flush;
    logic [SYM_BITS_MAX-1:0] bits;
    logic [2:0]              nbits;
  } slice_t;

  // Reserved mode code behaves as BPSK.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_BPSK : m;
  endfunction

  function automatic logic [2:0] bits_per_mode(input logic [1:0] m);
    case (m)
      MODE_QPSK:  return 3'd2;
      MODE_16QAM: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/iqdemap_slicer.sv
// Hard-decision slicer for one I/Q symbol, registered once before the packer.
module iqdemap_slicer
  import iqdemap_pkg::*;
#(
  parameter int unsigned IQ_W   = 11,
  parameter int unsigned THRESH = DEFAULT_THRESH
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   valid_i,
  input  logic                   flush,
  input  logic signed [IQ_W-1:0] ar,
  input  logic signed [IQ_W-1:0] ai,
  input  logic [1:0]             mode,
  output slice_t                 slice
);

  localparam int unsigned EXT_W = IQ_W + 1;

  logic [SYM_BITS_MAX-1:0] bits_c;

  // Extra bit lets the most negative sample map to a magnitude above THRESH.
  function automatic logic mag_bit(input logic signed [IQ_W-1:0] x);
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] absval;
    ext    = {x[IQ_W-1], x};
    absval = x[IQ_W-1] ? (~ext + EXT_W'(1)) : ext;
    return absval < EXT_W'(THRESH);
  endfunction

  always_comb begin
    bits_c = '0;
    case (mode)
      MODE_QPSK:  bits_c = {2'b00, ai[IQ_W-1], ar[IQ_W-1]};
      MODE_16QAM: bits_c = {mag_bit(ai), ai[IQ_W-1], mag_bit(ar), ar[IQ_W-1]};
      default:    bits_c = {3'b000, ar[IQ_W-1]};
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      slice <= '0;
    end else if (ce) begin
      slice.vld   <= valid_i;
      slice.flush <= flush;
      slice.bits  <= valid_i ? bits_c : '0;
      slice.nbits <= valid_i ? bits_per_mode(mode) : 3'd0;
    end
  end

endmodule

// File: rtl/iqdemap_multi.sv
// Multi-mode IQ demapper packing sliced bits LSB-first into WORD_W-bit words.
// Define IQDEMAP_RAW_EN to expose the per-symbol raw bit stream (valid_raw/raw).
module iqdemap_multi
  import iqdemap_pkg::*;
#(
  parameter int unsigned IQ_W   = 11,
  parameter int unsigned WORD_W = 128,
  parameter int unsigned THRESH = DEFAULT_THRESH
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     valid_i,
  input  logic signed [IQ_W-1:0]   ar,
  input  logic signed [IQ_W-1:0]   ai,
  input  logic [1:0]               mode,
  input  logic                     flush,
  output logic                     valid_o,
  output logic [WORD_W-1:0]        writer_data,
  output logic [$clog2(WORD_W):0]  nbits_o
`ifdef IQDEMAP_RAW_EN
  ,
  output logic                     valid_raw,
  output logic [3:0]               raw
`endif
);

  localparam int unsigned NB_W = $clog2(WORD_W) + 1;

  logic [1:0]        mode_q;
  logic [1:0]        eff_mode_c;
  logic [NB_W-1:0]   acc_fill_q;
  logic [NB_W-1:0]   acc_next_c;
  logic [NB_W-1:0]   fill_q;
  logic [NB_W-1:0]   fill_next_c;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] data_next_c;
  logic              emit_c;
  slice_t            slice;

  // acc_fill_q counts bits accepted into the open word, ahead of the slicer
  // stage, so the mode can be latched on the first symbol of every word.
  always_comb begin
    eff_mode_c = (acc_fill_q == '0) ? norm_mode(mode) : mode_q;
    acc_next_c = acc_fill_q + NB_W'(bits_per_mode(eff_mode_c));
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      mode_q     <= MODE_BPSK;
      acc_fill_q <= '0;
    end else if (ce) begin
      if (valid_i && acc_fill_q == '0) begin
        mode_q <= eff_mode_c;
      end
      if (flush) begin
        acc_fill_q <= '0;
      end else if (valid_i) begin
        acc_fill_q <= (acc_next_c == NB_W'(WORD_W)) ? '0 : acc_next_c;
      end
    end
  end

  iqdemap_slicer #(
    .IQ_W   (IQ_W),
    .THRESH (THRESH)
  ) u_slicer (
    .ck      (ck),
    .rst     (rst),
    .ce      (ce),
    .valid_i (valid_i),
    .flush   (flush),
    .ar      (ar),
    .ai      (ai),
    .mode    (eff_mode_c),
    .slice   (slice)
  );

  // Packer: merge the sliced symbol, then emit on a full word or a flush.
  always_comb begin
    fill_next_c = fill_q + (slice.vld ? NB_W'(slice.nbits) : '0);
    data_next_c = data_q | (WORD_W'(slice.bits) << fill_q);
    emit_c      = (fill_next_c == NB_W'(WORD_W)) ||
                  (slice.flush && fill_next_c != '0);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      valid_o     <= 1'b0;
      writer_data <= '0;
      nbits_o     <= '0;
      fill_q      <= '0;
      data_q      <= '0;
    end else if (ce) begin
      valid_o <= emit_c;
      if (emit_c) begin
        writer_data <= data_next_c;
        nbits_o     <= fill_next_c;
        fill_q      <= '0;
        data_q      <= '0;
      end else begin
        fill_q <= fill_next_c;
        data_q <= data_next_c;
      end
    end
  end

`ifdef IQDEMAP_RAW_EN
  assign valid_raw = slice.vld;
  assign raw       = slice.bits;
`endif

endmodule
